// File: rtl/muldiv_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_seq_ctrl_pkg
// Shared definitions for the HI/LO multiply/divide sequencer:
//   - operation codes (MULT, MULTU, DIV, DIVU)
//   - FSM state encoding (IDLE, BUSY, DONE)
//   - default iteration count (equals the 32-bit operand width)
//   - small decode helpers for the operation code
// -----------------------------------------------------------------------------
package muldiv_seq_ctrl_pkg;

    localparam int MULDIV_ITER = 32;

    localparam logic [1:0] MULDIV_MULT  = 2'b00;
    localparam logic [1:0] MULDIV_MULTU = 2'b01;
    localparam logic [1:0] MULDIV_DIV   = 2'b10;
    localparam logic [1:0] MULDIV_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == MULDIV_DIV) || (op == MULDIV_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MULDIV_MULT) || (op == MULDIV_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// -----------------------------------------------------------------------------
// muldiv_iter_core
// Iterative datapath for 32x32 multiply and 32/32 divide.
//   - On i_load: operands are reduced to magnitudes and the 64-bit accumulator
//     is seeded (low half = multiplier or dividend).
//   - On i_step: one shift-add (multiply) or shift-subtract (restoring divide)
//     step.
//   - o_hi/o_lo: sign-corrected result of the accumulator value the current
//     step is about to write, so the controller can capture the final result
//     on the same edge as the last step.
// Divide hardware is only built when MULDIV_DIV_EN is defined; otherwise a
// loaded divide reports a zero result.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_load        latch operands and op
//   i_step        perform one iteration
//   i_op [1:0]    operation code
//   i_src1 [31:0] multiplicand / dividend
//   i_src2 [31:0] multiplier / divisor
//   o_hi [31:0]   product[63:32] or remainder
//   o_lo [31:0]   product[31:0] or quotient
// -----------------------------------------------------------------------------
module muldiv_iter_core
    import muldiv_seq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_src1,
    input  logic [31:0] i_src2,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [63:0] r_acc;
    logic [31:0] r_b;
    logic        r_is_div;
    logic        r_neg_q;

    logic        w_is_div_in;
    logic        w_neg1;
    logic        w_neg2;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [32:0] w_sum;
    logic [63:0] w_mul_nxt;
    logic [63:0] w_acc_nxt;
    logic [63:0] w_prod;

    assign w_is_div_in = op_is_div(i_op);
    assign w_neg1      = op_is_signed(i_op) & i_src1[31];
    assign w_neg2      = op_is_signed(i_op) & i_src2[31];
    assign w_mag1      = w_neg1 ? (~i_src1 + 32'd1) : i_src1;
    assign w_mag2      = w_neg2 ? (~i_src2 + 32'd1) : i_src2;

    // Shift-add: add the multiplicand into the top half when the current
    // multiplier bit (acc[0]) is set, then shift the 65-bit result right.
    assign w_sum     = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_mul_nxt = {w_sum, r_acc[31:1]};
    assign w_prod    = r_neg_q ? (~w_acc_nxt + 64'd1) : w_acc_nxt;

`ifdef MULDIV_DIV_EN
    logic        r_neg_r;
    logic        r_dz;
    logic [31:0] r_src1;
    logic [31:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_rem_new;
    logic [63:0] w_div_nxt;
    logic [31:0] w_q;
    logic [31:0] w_r;

    // Restoring step. The shifted remainder is 33 bits wide; when its top
    // bit (acc[63]) is set it certainly exceeds the divisor, and the 32-bit
    // wrap-around difference is then still exact.
    assign w_rem_sh  = r_acc[62:31];
    assign w_ge      = r_acc[63] | (w_rem_sh >= r_b);
    assign w_rem_new = w_ge ? (w_rem_sh - r_b) : w_rem_sh;
    assign w_div_nxt = {w_rem_new, r_acc[30:0], w_ge};
    assign w_acc_nxt = r_is_div ? w_div_nxt : w_mul_nxt;

    assign w_q = r_neg_q ? (~w_acc_nxt[31:0] + 32'd1) : w_acc_nxt[31:0];
    assign w_r = r_neg_r ? (~w_acc_nxt[63:32] + 32'd1) : w_acc_nxt[63:32];

    // Divide by zero reports all-ones quotient and the raw dividend.
    assign o_hi = r_is_div ? (r_dz ? r_src1 : w_r) : w_prod[63:32];
    assign o_lo = r_is_div ? (r_dz ? 32'hFFFF_FFFF : w_q) : w_prod[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_src1  <= 32'd0;
        end else if (i_load) begin
            r_neg_r <= w_neg1;
            r_dz    <= (i_src2 == 32'd0);
            r_src1  <= i_src1;
        end
    end
`else
    assign w_acc_nxt = w_mul_nxt;
    assign o_hi      = r_is_div ? 32'd0 : w_prod[63:32];
    assign o_lo      = r_is_div ? 32'd0 : w_prod[31:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= 64'd0;
            r_b      <= 32'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
        end else if (i_load) begin
            r_acc    <= {32'd0, (w_is_div_in ? w_mag1 : w_mag2)};
            r_b      <= w_is_div_in ? w_mag2 : w_mag1;
            r_is_div <= w_is_div_in;
            r_neg_q  <= w_neg1 ^ w_neg2;
        end else if (i_step) begin
            r_acc    <= w_acc_nxt;
        end
    end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_seq_ctrl
// Multi-cycle sequencer for MULT/MULTU/DIV/DIVU. Accepts an op from EX in
// IDLE, iterates ITER cycles in BUSY while holding the pipeline through
// stallreq, then presents the result in DONE with one-cycle HI/LO strobes.
//
// Handshake: start is sampled only in IDLE and only when cancel is low; the
// op is accepted on that cycle and stallreq rises combinationally so EX holds.
// start seen in BUSY/DONE is ignored. The strobes mark the single cycle in
// which hi_o/lo_o carry a new result and the pipeline advances.
//
// Build option MULDIV_DIV_EN: when undefined, DIV/DIVU skip BUSY, do not stall
// and complete on the next cycle with a zero result.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           EX presents a mul/div op
//   op [1:0]        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src1, src2      rs / rt operands
//   cancel          flush; aborts the op in flight, suppresses strobes
//   stallreq        freeze IF..EX
//   busy            high in BUSY and DONE
//   hi_we, lo_we    one-cycle write strobes
//   hi_o, lo_o      registered result, held until the next DONE
// -----------------------------------------------------------------------------
module muldiv_seq_ctrl
    import muldiv_seq_ctrl_pkg::*;
#(
    parameter int ITER = MULDIV_ITER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        cancel,
    output logic        stallreq,
    output logic        busy,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CW = $clog2(ITER + 1);

`ifdef MULDIV_DIV_EN
    localparam logic DIV_HW = 1'b1;
`else
    localparam logic DIV_HW = 1'b0;
`endif

    md_state_e     r_state;
    md_state_e     w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    logic          w_accept;
    logic          w_bypass;
    logic          w_last;
    logic [31:0]   w_core_hi;
    logic [31:0]   w_core_lo;

    assign w_accept = (r_state == MD_IDLE) && start && !cancel;
    // Divide without divide hardware: straight to DONE with a zero result.
    assign w_bypass = w_accept && !DIV_HW && op_is_div(op);
    // Final iteration: the counter is about to reach zero.
    assign w_last   = (r_state == MD_BUSY) && !cancel && (r_cnt == CW'(1));

    muldiv_iter_core u_core (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept && !w_bypass),
        .i_step (r_state == MD_BUSY),
        .i_op   (op),
        .i_src1 (src1),
        .i_src2 (src2),
        .o_hi   (w_core_hi),
        .o_lo   (w_core_lo)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= MD_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            MD_IDLE: begin
                if (w_bypass)      w_next = MD_DONE;
                else if (w_accept) w_next = MD_BUSY;
            end
            MD_BUSY: begin
                if (cancel)      w_next = MD_IDLE;
                else if (w_last) w_next = MD_DONE;
            end
            MD_DONE: w_next = MD_IDLE;
            default: w_next = MD_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        stallreq = 1'b0;
        busy     = 1'b0;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        case (r_state)
            MD_IDLE: stallreq = w_accept && !w_bypass;
            MD_BUSY: begin
                stallreq = 1'b1;
                busy     = 1'b1;
            end
            MD_DONE: begin
                busy  = 1'b1;
                hi_we = !cancel;
                lo_we = !cancel;
            end
            default: ;
        endcase
    end

    // Iteration counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
        end else begin
            if (w_accept && !w_bypass)
                r_cnt <= CW'(ITER);
            else if (r_state == MD_BUSY && !cancel)
                r_cnt <= r_cnt - CW'(1);
            else if (r_state == MD_BUSY)
                r_cnt <= '0;

            if (w_last) begin
                r_hi <= w_core_hi;
                r_lo <= w_core_lo;
            end else if (w_bypass) begin
                r_hi <= 32'd0;
                r_lo <= 32'd0;
            end
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
module tb_muldiv_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        cancel;
  logic        stallreq;
  logic        busy;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_strobes = 0;
  logic prev_we = 1'b0;

  // {hi, lo, strobe cycle}
  logic [95:0] exp_q[$];

  muldiv_seq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src1     (src1),
    .src2     (src2),
    .cancel   (cancel),
    .stallreq (stallreq),
    .busy     (busy),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // reference model: plain 64-bit arithmetic
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lat = 33;
    p   = 64'd0;
    case (o)
      2'b00: p = sa * sb;
      2'b01: p = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) begin
          p = {a, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {a % b, a / b};
        end
`ifndef MULDIV_DIV_EN
        p   = 64'd0;
        lat = 1;
`endif
      end
    endcase
    hi = p[63:32];
    lo = p[31:0];
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [95:0] e;
    if (hi_we || lo_we) begin
      n_strobes++;
      check("we_pair", 64'(lo_we), 64'(hi_we));
      check("strobe_one_cycle", 64'(prev_we), 64'd0);
      check("stall_in_done", 64'(stallreq), 64'd0);
      check("busy_in_done", 64'(busy), 64'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_strobe: got strobe at cycle %0d, required none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("hi_o", 64'(hi_o), 64'(e[95:64]));
        check("lo_o", 64'(lo_o), 64'(e[63:32]));
        check("strobe_cycle", 64'(cyc), 64'(e[31:0]));
      end
    end
    prev_we = hi_we | lo_we;
  end

  // driver tasks
  task automatic drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh;
    logic [31:0] el;
    int lat;
    int nst;
    model(o, a, b, eh, el, lat);
    @(posedge clk); #1;
    start = 1'b1; op = o; src1 = a; src2 = b;
    exp_q.push_back({eh, el, 32'(cyc + lat)});
    @(negedge clk);
    check("stall_cycle0", 64'(stallreq), 64'(lat > 1));
    nst = stallreq ? 1 : 0;
    @(posedge clk); #1;
    start = 1'b0; src1 = $urandom; src2 = $urandom;
    for (int k = 0; k < lat + 10; k++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
      if (stallreq) nst++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check("stall_cycles", 64'(nst), 64'((lat > 1) ? lat : 0));
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic abort_in_busy(input logic use_rst);
    int ns0;
    ns0 = n_strobes;
    @(posedge clk); #1;
    start = 1'b1; op = 2'($urandom_range(0, 1)); src1 = $urandom; src2 = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1; else cancel = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cancel = 1'b0;
    @(negedge clk);
    check(use_rst ? "rst_busy_idle" : "cancel_busy_idle", 64'(busy), 64'd0);
    check(use_rst ? "rst_busy_stall" : "cancel_busy_stall", 64'(stallreq), 64'd0);
    repeat (40) @(negedge clk);
    check(use_rst ? "rst_no_strobe" : "cancel_no_strobe", 64'(n_strobes), 64'(ns0));
    check(use_rst ? "rst_hi_o" : "cancel_hi_hold", 64'(hi_o), 64'd0);
    check(use_rst ? "rst_lo_o" : "cancel_lo_hold", 64'(lo_o), use_rst ? 64'd0 : 64'd15);
  endtask

  task automatic back_to_back(input logic [31:0] a1, input logic [31:0] b1,
                              input logic [31:0] a2, input logic [31:0] b2);
    logic [31:0] eh;
    logic [31:0] el;
    int lat;
    int t0;
    @(posedge clk); #1;
    t0 = cyc;
    model(2'b01, a1, b1, eh, el, lat);
    start = 1'b1; op = 2'b01; src1 = a1; src2 = b1;
    exp_q.push_back({eh, el, 32'(t0 + 33)});
    @(posedge clk); #1;
    model(2'b11, a2, b2, eh, el, lat);
    op = 2'b11; src1 = a2; src2 = b2;
    exp_q.push_back({eh, el, 32'(t0 + 34 + lat)});
    repeat (34) @(posedge clk);
    #1;
    start = 1'b0;
    drain(50);
  endtask

  // main stimulus
  initial begin
    int ns0;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; src1 = 32'd0; src2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_stallreq", 64'(stallreq), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_we", 64'({hi_we, lo_we}), 64'd0);
    check("rst_hi_o", 64'(hi_o), 64'd0);
    check("rst_lo_o", 64'(lo_o), 64'd0);

    // directed cases, including the boundary rules
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    issue(2'b11, 32'd7, 32'd0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b10, 32'hFFFF_FFFB, 32'd0);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    issue(2'b11, 32'hFFFF_FFFF, 32'd1);
    issue(2'b10, 32'd100, 32'hFFFF_FFF9);

    // randomized ops
    for (int i = 0; i < 40; i++)
      issue(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand());

    // cancel in BUSY keeps previous result; rst in BUSY zeroes it
    issue(2'b01, 32'd3, 32'd5);
    abort_in_busy(1'b0);
    issue(2'b01, 32'd3, 32'd5);
    abort_in_busy(1'b1);
    issue(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand());

    // cancel during DONE suppresses the strobes
    ns0 = n_strobes;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; src1 = $urandom; src2 = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(negedge clk);
    check("done_cancel_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    check("done_cancel_idle", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    check("done_cancel_no_strobe", 64'(n_strobes), 64'(ns0));

    // cancel together with start in IDLE: start ignored
    ns0 = n_strobes;
    @(posedge clk); #1;
    start = 1'b1; cancel = 1'b1; op = 2'b00; src1 = $urandom; src2 = $urandom;
    @(negedge clk);
    check("cancel_start_stall", 64'(stallreq), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    check("cancel_start_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    check("cancel_start_no_strobe", 64'(n_strobes), 64'(ns0));

    // back-to-back with start held through BUSY/DONE
    back_to_back(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd7);
    back_to_back($urandom, $urandom, $urandom, rnd_operand());

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
